// File: rtl/inv_sub_bytes_seq.sv
// AES decryption InvSubBytes stage: substitutes the 128-bit state through the
// inverse S-box, BYTES_PER_CYCLE bytes per clock, with a start/done handshake.
module inv_sub_bytes_seq #(
  parameter int BYTES_PER_CYCLE = 1
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         startTransition,
  input  logic [127:0] inputData,
  output logic [127:0] outputData,
  output logic         busy,
  output logic         done
);

  localparam int N = 16 / BYTES_PER_CYCLE;
  localparam logic [3:0] LAST = 4'(N - 1);

  if (!(BYTES_PER_CYCLE == 1 || BYTES_PER_CYCLE == 2 || BYTES_PER_CYCLE == 4)) begin : g_bad_param
    $error("inv_sub_bytes_seq: BYTES_PER_CYCLE must be 1, 2 or 4");
  end

  localparam logic [7:0] INV_SBOX [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

  typedef enum logic {IDLE, BUSY} state_t;

  state_t       state;
  state_t       next_state;
  logic [3:0]   counter;
  logic [127:0] work_reg;
  logic [127:0] sub_word;
  logic [3:0]   byte_idx;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (startTransition) next_state = BUSY;
      BUSY: if (counter == LAST) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Byte 0 sits in the top lane, so lane index is the bitwise complement of the byte index
  always_comb begin
    sub_word = work_reg;
    byte_idx = '0;
    for (int i = 0; i < BYTES_PER_CYCLE; i++) begin
      byte_idx = 4'(counter * BYTES_PER_CYCLE + i);
      sub_word[{~byte_idx, 3'b000} +: 8] = INV_SBOX[work_reg[{~byte_idx, 3'b000} +: 8]];
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      counter    <= '0;
      work_reg   <= '0;
      outputData <= '0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (startTransition) begin
            work_reg <= inputData;
            counter  <= '0;
          end
        end
        BUSY: begin
          work_reg <= sub_word;
          if (counter == LAST) begin
            outputData <= sub_word;
            done       <= 1'b1;
            counter    <= '0;
          end else begin
            counter <= counter + 4'd1;
          end
        end
        default: counter <= '0;
      endcase
    end
  end

  assign busy = (state == BUSY);

endmodule

// File: tb/tb_inv_sub_bytes_seq.sv
// Self-checking bench for inv_sub_bytes_seq: three instances (1, 2 and 4 bytes per
// cycle) checked against a GF(2^8) arithmetic model of the AES S-box.
module tb_inv_sub_bytes_seq;

  logic         clock;
  logic         reset;
  logic         startTransition;
  logic [127:0] inputData;
  logic [127:0] out_v  [3];
  logic         busy_v [3];
  logic         done_v [3];

  int checks;
  int failures;

  logic [7:0] inv_tab [256];
  logic [7:0] fwd_tab [256];

  typedef struct {
    string        name;
    logic [127:0] din;
    logic [127:0] exp;
  } vec_t;

  vec_t vecs[4];

  inv_sub_bytes_seq #(.BYTES_PER_CYCLE(1)) dut1 (
    .clock(clock), .reset(reset), .startTransition(startTransition), .inputData(inputData),
    .outputData(out_v[0]), .busy(busy_v[0]), .done(done_v[0]));
  inv_sub_bytes_seq #(.BYTES_PER_CYCLE(2)) dut2 (
    .clock(clock), .reset(reset), .startTransition(startTransition), .inputData(inputData),
    .outputData(out_v[1]), .busy(busy_v[1]), .done(done_v[1]));
  inv_sub_bytes_seq #(.BYTES_PER_CYCLE(4)) dut4 (
    .clock(clock), .reset(reset), .startTransition(startTransition), .inputData(inputData),
    .outputData(out_v[2]), .busy(busy_v[2]), .done(done_v[2]));

  always #5 clock = ~clock;

  function automatic logic [7:0] rotl(input logic [7:0] x, input int n);
    logic [15:0] t;
    t = {x, x} << n;
    return t[15:8];
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a, b, p;
    logic hi;
    a = a_in; b = b_in; p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      hi = a[7];
      a = a << 1;
      if (hi) a = a ^ 8'h1b;
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] ginv(input logic [7:0] x);
    logic [7:0] r;
    r = 8'h00;
    if (x != 8'h00)
      for (int z = 1; z < 256; z++)
        if (gmul(x, 8'(z)) == 8'h01) r = 8'(z);
    return r;
  endfunction

  // Forward S-box = affine(inverse); inverse S-box = inverse(inverse-affine)
  task automatic build_model();
    logic [7:0] v, s;
    for (int k = 0; k < 256; k++) begin
      v = 8'(k);
      s = rotl(v, 1) ^ rotl(v, 3) ^ rotl(v, 6) ^ 8'h05;
      inv_tab[k] = ginv(s);
      s = ginv(v);
      fwd_tab[k] = s ^ rotl(s, 1) ^ rotl(s, 2) ^ rotl(s, 3) ^ rotl(s, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [127:0] model_inv(input logic [127:0] din);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[i*8 +: 8] = inv_tab[din[i*8 +: 8]];
    return r;
  endfunction

  task automatic check_output(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One accepted block on all three instances; checks latency, single done pulse, result and busy
  task automatic apply_stimulus(input string name, input logic [127:0] din, input logic [127:0] exp,
                                output logic [127:0] res0);
    int lat[3];
    int pulses[3];
    logic [127:0] res[3];
    int busy_bad;
    busy_bad = 0;
    for (int d = 0; d < 3; d++) begin lat[d] = 0; pulses[d] = 0; res[d] = '0; end
    @(negedge clock);
    inputData = din;
    startTransition = 1'b1;
    @(posedge clock); #1;
    startTransition = 1'b0;
    inputData = {$urandom, $urandom, $urandom, $urandom};
    check_output({name, " busy_after_accept"}, {125'd0, busy_v[0], busy_v[1], busy_v[2]}, 128'h7);
    for (int cyc = 1; cyc <= 20; cyc++) begin
      @(posedge clock); #1;
      for (int d = 0; d < 3; d++) begin
        if (done_v[d]) begin
          pulses[d]++;
          if (lat[d] == 0) begin lat[d] = cyc; res[d] = out_v[d]; end
        end
      end
      if (cyc < 16 && busy_v[0] !== 1'b1) busy_bad++;
      if (cyc >= 16 && busy_v[0] !== 1'b0) busy_bad++;
    end
    for (int d = 0; d < 3; d++) begin
      check_output($sformatf("%s latency_B%0d", name, 1 << d), 128'(lat[d]), 128'(16 >> d));
      check_output($sformatf("%s pulses_B%0d", name, 1 << d), 128'(pulses[d]), 128'd1);
      check_output($sformatf("%s data_B%0d", name, 1 << d), res[d], exp);
    end
    check_output({name, " busy_profile_errors"}, 128'(busy_bad), 128'd0);
    check_output({name, " data_held"}, out_v[0], exp);
    res0 = res[0];
  endtask

  initial begin
    logic [127:0] res, din, sb, pat_a, pat_b;
    int dones, done_cyc[4];
    logic [127:0] done_out[4];

    checks = 0; failures = 0;
    clock = 1'b0; reset = 1'b1; startTransition = 1'b0; inputData = '0;
    build_model();

    vecs[0] = '{"fips_c1", 128'h7a9f102789d5f50b2beffd9f3dca4ea7, 128'hbd6e7c3df2b5779e0b61216e8b10b689};
    vecs[1] = '{"all_63", {16{8'h63}}, 128'h0};
    vecs[2] = '{"all_16", {16{8'h16}}, {16{8'hff}}};
    vecs[3] = '{"all_00", {16{8'h00}}, {16{8'h52}}};

    #12;
    check_output("reset_out", out_v[0], 128'h0);
    check_output("reset_busy_done", {126'd0, busy_v[0], done_v[0]}, 128'h0);
    @(negedge clock); reset = 1'b0;

    for (int i = 0; i < 4; i++) apply_stimulus(vecs[i].name, vecs[i].din, vecs[i].exp, res);

    // Random blocks against the arithmetic model
    for (int i = 0; i < 20; i++) begin
      din = {$urandom, $urandom, $urandom, $urandom};
      apply_stimulus("random", din, model_inv(din), res);
    end

    // Second start at E+3 with different data must be ignored
    pat_a = {$urandom, $urandom, $urandom, $urandom};
    pat_b = ~pat_a;
    dones = 0; done_cyc[0] = 0; done_out[0] = '0;
    @(negedge clock); inputData = pat_a; startTransition = 1'b1;
    @(posedge clock); #1; startTransition = 1'b0;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(posedge clock); #1;
      if (cyc == 2) begin startTransition = 1'b1; inputData = pat_b; end
      if (cyc == 3) startTransition = 1'b0;
      if (done_v[0]) begin
        if (dones == 0) begin done_cyc[0] = cyc; done_out[0] = out_v[0]; end
        dones++;
      end
    end
    check_output("ignore_start pulses", 128'(dones), 128'd1);
    check_output("ignore_start latency", 128'(done_cyc[0]), 128'd16);
    check_output("ignore_start data", done_out[0], model_inv(pat_a));

    // Asynchronous reset between edges at E+7 discards the transform
    @(negedge clock); inputData = vecs[0].din; startTransition = 1'b1;
    @(posedge clock); #1; startTransition = 1'b0;
    repeat (7) @(posedge clock);
    #2 reset = 1'b1;
    #1;
    check_output("async_reset out", out_v[0], 128'h0);
    check_output("async_reset busy_done", {124'd0, busy_v[0], done_v[0], busy_v[2], done_v[2]}, 128'h0);
    #1 reset = 1'b0;
    dones = 0;
    for (int cyc = 0; cyc < 25; cyc++) begin
      @(posedge clock); #1;
      if (done_v[0] || done_v[1] || done_v[2] || busy_v[0]) dones++;
    end
    check_output("async_reset no_activity", 128'(dones), 128'd0);
    apply_stimulus("after_reset", vecs[0].din, vecs[0].exp, res);

    // startTransition held high: restarts every 17 cycles, data alternating per accept
    dones = 0;
    for (int j = 0; j < 4; j++) begin done_cyc[j] = 0; done_out[j] = '0; end
    @(negedge clock); inputData = '0; startTransition = 1'b1;
    @(posedge clock); #1;
    for (int cyc = 1; cyc <= 90 && dones < 4; cyc++) begin
      @(posedge clock); #1;
      if (done_v[0]) begin
        done_cyc[dones] = cyc;
        done_out[dones] = out_v[0];
        dones++;
        inputData = (dones % 2 == 1) ? {16{8'h16}} : 128'h0;
        if (dones == 4) startTransition = 1'b0;
      end
    end
    startTransition = 1'b0;
    check_output("continuous dones", 128'(dones), 128'd4);
    check_output("continuous first_latency", 128'(done_cyc[0]), 128'd16);
    for (int j = 1; j < 4; j++)
      check_output($sformatf("continuous spacing_%0d", j), 128'(done_cyc[j] - done_cyc[j-1]), 128'd17);
    for (int j = 0; j < 4; j++)
      check_output($sformatf("continuous data_%0d", j), done_out[j], (j % 2 == 0) ? {16{8'h52}} : {16{8'hff}});
    repeat (20) @(posedge clock);

    // Exhaustive byte sweep, plus forward S-box round trip
    for (int k = 0; k < 256; k++) begin
      din = {16{8'(k)}};
      apply_stimulus($sformatf("sweep_%0d", k), din, {16{inv_tab[k]}}, res);
      for (int i = 0; i < 16; i++) sb[i*8 +: 8] = fwd_tab[res[i*8 +: 8]];
      check_output($sformatf("roundtrip_%0d", k), sb, din);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
